// File: rtl/pixel_mem_arbiter.sv
// Video memory arbiter: display reads take absolute priority over a four-phase host
// write port; read data is brightness-adjusted with a frame-synchronous offset.
module pixel_mem_arbiter #(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int H_START = 145,
    parameter int V_START = 32,
    parameter int STEP    = 16
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic [9:0]  horizontal_counter,
    input  logic [9:0]  vertical_counter,
    input  logic        output_signal,
    input  logic        bright_up,
    input  logic        bright_down,
    input  logic        host_req,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  pixel_out,
    output logic        pixel_valid,
    output logic [8:0]  bright_level
);

    localparam logic [9:0]         H_ST    = 10'(H_START);
    localparam logic [9:0]         V_ST    = 10'(V_START);
    localparam logic [10:0]        W_LIM   = 11'(IMG_W);
    localparam logic [10:0]        H_LIM   = 11'(IMG_H);
    localparam logic [9:0]         COPY_V  = 10'(V_START + IMG_H);
    localparam logic signed [9:0]  STEP_D  = 10'(STEP);
    localparam logic signed [9:0]  OFS_MAX = 10'sd255;
    localparam logic signed [9:0]  OFS_MIN = -10'sd255;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ACK
    } host_state_t;

    host_state_t state, next_state;

    logic [9:0]        x, y;
    logic              in_window;
    logic              write_issue;
    logic [15:0]       addr_q;
    logic [7:0]        wdata_q;

    logic signed [8:0] pending_offset, active_offset;
    logic signed [9:0] delta, pend_sum;
    logic signed [8:0] pend_next;
    logic              copy_frame;

    logic              rd_valid_q;
    logic signed [9:0] pix_sum;
    logic [7:0]        pix_clamped;

    // Counters left of / above the window wrap to large values and fall outside.
    always_comb begin
        x         = horizontal_counter - H_ST;
        y         = vertical_counter - V_ST;
        in_window = output_signal && ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (host_req) next_state = WRITE;
            WRITE:   if (!in_window) next_state = ACK;
            ACK:     if (!host_req) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        host_ack    = (state == ACK);
        write_issue = (state == WRITE) && !in_window;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && host_req) begin
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (clear_n) begin
            if (in_window) begin
                mem_en   = 1'b1;
                mem_addr = {y[7:0], x[7:0]};
            end else if (write_issue) begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
        end
    end

    always_comb begin
        delta = '0;
        if (bright_up && !bright_down) begin
            delta = STEP_D;
        end else if (bright_down && !bright_up) begin
            delta = -STEP_D;
        end
        pend_sum = {pending_offset[8], pending_offset} + delta;
        if (pend_sum > OFS_MAX) begin
            pend_next = OFS_MAX[8:0];
        end else if (pend_sum < OFS_MIN) begin
            pend_next = OFS_MIN[8:0];
        end else begin
            pend_next = pend_sum[8:0];
        end
        copy_frame = (vertical_counter == COPY_V) && (horizontal_counter == '0);
    end

    // The copy takes the pre-edge pending value, so a pulse on the copy cycle waits a frame.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pending_offset <= '0;
            active_offset  <= '0;
        end else begin
            pending_offset <= pend_next;
            if (copy_frame) begin
                active_offset <= pending_offset;
            end
        end
    end

    always_comb begin
        pix_sum = $signed({2'b00, mem_rdata}) + $signed({active_offset[8], active_offset});
        if (pix_sum < 10'sd0) begin
            pix_clamped = '0;
        end else if (pix_sum > 10'sd255) begin
            pix_clamped = '1;
        end else begin
            pix_clamped = pix_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rd_valid_q  <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_out   <= '0;
        end else begin
            rd_valid_q  <= in_window;
            pixel_valid <= rd_valid_q;
            pixel_out   <= rd_valid_q ? pix_clamped : '0;
        end
    end

    assign bright_level = active_offset;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Directed and randomized bench for pixel_mem_arbiter; the bench owns the memory
// array and predicts every output from window, handshake and offset rules.
module tb_pixel_mem_arbiter;

    localparam int IMG_W   = 256;
    localparam int IMG_H   = 256;
    localparam int H_START = 145;
    localparam int V_START = 32;
    localparam int STEP    = 16;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic [9:0]  hc = '0;
    logic [9:0]  vc = '0;
    logic        os = 1'b0;
    logic        bright_up = 1'b0;
    logic        bright_down = 1'b0;
    logic        host_req = 1'b0;
    logic [15:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_ack;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pixel_out;
    logic        pixel_valid;
    logic [8:0]  bright_level;

    pixel_mem_arbiter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .H_START(H_START), .V_START(V_START), .STEP(STEP)
    ) dut (
        .clk(clk), .clear_n(clear_n),
        .horizontal_counter(hc), .vertical_counter(vc), .output_signal(os),
        .bright_up(bright_up), .bright_down(bright_down),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid), .bright_level(bright_level)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [65536];

    int checks = 0;
    int errors = 0;

    // reference model state
    bit wr_pending, ack_phase, rd_prev, exp_valid;
    int haddr, hdata, pend, act, exp_pix, rdata_drv;
    int n_writes, write_h, write_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int sat255(input int v);
        if (v < -255) return -255;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic model_reset();
        wr_pending = 0; ack_phase = 0; rd_prev = 0; exp_valid = 0;
        pend = 0; act = 0; exp_pix = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic cycle();
        int x, y, e_addr, nxt_rd, d;
        bit win, e_en, e_we, req, up, dn;
        #2;
        x   = int'(hc) - H_START;
        y   = int'(vc) - V_START;
        win = os && x >= 0 && x < IMG_W && y >= 0 && y < IMG_H;
        e_en = win || wr_pending;
        e_we = !win && wr_pending;
        e_addr = win ? ((y % 256) * 256 + (x % 256)) : haddr;
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(hdata));
        chk("host_ack", 32'(host_ack), 32'(ack_phase));
        chk("pixel_valid", 32'(pixel_valid), 32'(exp_valid));
        chk("pixel_out", 32'(pixel_out), 32'(exp_pix));
        chk("bright_level", 32'($signed(bright_level)), 32'(act));
        if (mem_we === 1'b1) begin
            n_writes++; write_h = int'(hc); write_addr = int'(mem_addr);
        end
        req = host_req; up = bright_up; dn = bright_down;
        @(posedge clk);
        exp_valid = rd_prev;
        exp_pix   = rd_prev ? clamp8(rdata_drv + act) : 0;
        nxt_rd    = win ? int'(mem[e_addr]) : int'($urandom_range(0, 255));
        rd_prev   = win;
        if (e_we) mem[haddr] = 8'(hdata);
        if (!wr_pending && !ack_phase && req) begin
            wr_pending = 1; haddr = int'(host_addr); hdata = int'(host_wdata);
        end else if (wr_pending && !win) begin
            wr_pending = 0; ack_phase = 1;
        end else if (ack_phase && !req) begin
            ack_phase = 0;
        end
        if (int'(vc) == V_START + IMG_H && hc == 10'd0) act = pend;
        d = (up && !dn) ? STEP : ((dn && !up) ? -STEP : 0);
        pend = sat255(pend + d);
        #1;
        rdata_drv = nxt_rd;
        mem_rdata = 8'(nxt_rd);
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("rst_pixel_out", 32'(pixel_out), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_bright", 32'($signed(bright_level)), 32'd0);
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        model_reset();
    endtask

    task automatic set_cnt(input int h, input int v, input bit o);
        hc = 10'(h); vc = 10'(v); os = o;
    endtask

    task automatic frame_copy();
        set_cnt(0, V_START + IMG_H, 0);
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
        model_reset();
        rdata_drv = 0;
        #1;
        set_cnt(H_START, V_START, 1);   // window counters: reset must still hold mem_en low
        do_reset();

        // first pixel of the frame
        mem[0] = 8'h40;
        set_cnt(H_START, V_START, 1);
        cycle();
        set_cnt(10, 10, 0);
        cycle();
        chk("px_first_out", 32'(pixel_out), 32'h40);
        chk("px_first_valid", 32'(pixel_valid), 32'd1);
        cycle();
        chk("px_idle_valid", 32'(pixel_valid), 32'd0);

        // host write stalled across the active line, issued at h=401
        n_writes = 0; write_h = -1; write_addr = -1;
        host_addr = 16'h1234; host_wdata = 8'hAA; host_req = 1'b1;
        for (int h = 200; h <= 403; h++) begin
            set_cnt(h, 40, 1);
            cycle();
        end
        chk("wr_count", 32'(n_writes), 32'd1);
        chk("wr_h", 32'(write_h), 32'd401);
        chk("wr_addr", 32'(write_addr), 32'h1234);
        chk("wr_mem", 32'(mem[16'h1234]), 32'hAA);
        chk("ack_held", 32'(host_ack), 32'd1);
        cycle();
        host_req = 1'b0;
        cycle();
        chk("ack_drop", 32'(host_ack), 32'd0);

        // three up pulses mid-frame, visible only after the frame copy
        for (int i = 0; i < 3; i++) begin
            set_cnt(300 + i, 100, 0);
            bright_up = 1'b1; cycle(); bright_up = 1'b0; cycle();
        end
        chk("bright_midframe", 32'($signed(bright_level)), 32'd0);
        frame_copy();
        chk("bright_up48", 32'($signed(bright_level)), 32'd48);
        mem[16'h0505] = 8'hF0;
        set_cnt(H_START + 5, V_START + 5, 1);
        cycle();
        set_cnt(5, 5, 0);
        cycle();
        chk("px_clamp_hi", 32'(pixel_out), 32'hFF);

        // saturate low, then simultaneous pulses change nothing
        for (int i = 0; i < 20; i++) begin
            set_cnt(20, 50 + i, 0);
            bright_down = 1'b1; cycle(); bright_down = 1'b0;
        end
        frame_copy();
        chk("bright_sat_lo", 32'($signed(bright_level)), 32'(-255));
        mem[16'h0a0a] = 8'h10;
        set_cnt(H_START + 10, V_START + 10, 1);
        cycle();
        set_cnt(5, 5, 0);
        cycle();
        chk("px_clamp_lo", 32'(pixel_out), 32'd0);
        chk("px_clamp_lo_valid", 32'(pixel_valid), 32'd1);
        bright_up = 1'b1; bright_down = 1'b1; cycle();
        bright_up = 1'b0; bright_down = 1'b0;
        frame_copy();
        chk("bright_both", 32'($signed(bright_level)), 32'(-255));
        // pulse on the copy cycle waits for the next frame
        bright_up = 1'b1; frame_copy(); bright_up = 1'b0;
        chk("bright_copy_pulse", 32'($signed(bright_level)), 32'(-255));
        frame_copy();
        chk("bright_next_frame", 32'($signed(bright_level)), 32'(-239));

        // reset in the middle of a stalled write abandons it
        n_writes = 0;
        host_addr = 16'h4321; host_wdata = 8'h55; host_req = 1'b1;
        set_cnt(H_START + 20, V_START + 8, 1);
        cycle();
        cycle();
        host_req = 1'b0;
        do_reset();
        chk("abort_ack", 32'(host_ack), 32'd0);
        chk("abort_bright", 32'($signed(bright_level)), 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_cnt(500, 500, 0);
            cycle();
        end
        chk("abort_no_write", 32'(n_writes), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                set_cnt(0, V_START + IMG_H, 0);
            end else begin
                hc = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(140, 405)) : 10'($urandom_range(0, 1023));
                vc = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(28, 292)) : 10'($urandom_range(0, 1023));
                os = ($urandom_range(0, 9) != 0);
            end
            bright_up   = ($urandom_range(0, 9) == 0);
            bright_down = ($urandom_range(0, 9) == 0);
            if (!host_req && $urandom_range(0, 7) == 0) begin
                host_req = 1'b1;
                host_addr = 16'($urandom_range(0, 65535));
                host_wdata = 8'($urandom_range(0, 255));
            end else if (host_req && host_ack && $urandom_range(0, 1) == 0) begin
                host_req = 1'b0;
            end
            if ($urandom_range(0, 999) == 0) begin
                host_req = 1'b0;
                do_reset();
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
